// File: rtl/service_reply_encoder.sv
// Purpose: frames a service reply (addr, size/cmd, payload, checksum, word number, postfix) onto the SPI push path.
// Latency: first word is presented on the edge that accepts start; each word takes two cycles with zero-wait acks.
// Backpressure: push/pop requests hold until the matching one-cycle done pulse; start is dropped while busy.
module service_reply_encoder #(
    parameter int POSTFIX_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  addr,
    input  logic [7:0]  cmd,
    input  logic [7:0]  size,
    output logic        busy,
    output logic        done,
    output logic        pop_request,
    input  logic [15:0] pop_data,
    input  logic        pop_done,
    output logic        push_request,
    output logic [15:0] push_data,
    input  logic        push_done,
    output logic [15:0] word_num
);

    localparam logic [3:0] LP_POST = 4'(POSTFIX_WORDS);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_HDR,
        ST_POP,
        ST_DATA,
        ST_CSUM,
        ST_WNUM,
        ST_POST,
        ST_FIN
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_pop_req;
    logic        r_push_req;
    logic [15:0] r_push_data;
    logic [15:0] r_word_num;
    logic [15:0] r_csum;
    logic [7:0]  r_cmd;
    logic [7:0]  r_size;
    logic [7:0]  r_remain;
    logic [3:0]  r_post_cnt;

    state_t      w_state;
    logic        w_busy;
    logic        w_done;
    logic        w_pop_req;
    logic        w_push_req;
    logic [15:0] w_push_data;
    logic [15:0] w_word_num;
    logic [15:0] w_csum;
    logic [7:0]  w_cmd;
    logic [7:0]  w_size;
    logic [7:0]  w_remain;
    logic [3:0]  w_post_cnt;
    logic        w_push_acc;
    logic        w_pop_acc;
    logic [15:0] w_csum_sum;

    // Handshake qualifiers: acknowledges count only while the matching request is up.
    assign w_push_acc = r_push_req & push_done;
    assign w_pop_acc  = r_pop_req & pop_done;
    // Running checksum including the word currently being accepted.
    assign w_csum_sum = r_csum + r_push_data;

    // Next-state and next-output decode; every registered value defaults to hold.
    always_comb begin
        w_state     = r_state;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_pop_req   = r_pop_req;
        w_push_req  = r_push_req;
        w_push_data = r_push_data;
        w_word_num  = r_word_num;
        w_csum      = r_csum;
        w_cmd       = r_cmd;
        w_size      = r_size;
        w_remain    = r_remain;
        w_post_cnt  = r_post_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cmd       = cmd;
                    w_size      = size;
                    w_remain    = size;
                    w_csum      = 16'h0000;
                    w_post_cnt  = LP_POST;
                    w_busy      = 1'b1;
                    // The address word goes out immediately; it does not need r_addr.
                    w_push_req  = 1'b1;
                    w_push_data = {addr, 8'h00};
                    w_state     = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (w_push_acc) begin
                    w_csum      = w_csum_sum;
                    w_push_req  = 1'b0;
                    w_push_data = {r_size, r_cmd};
                    w_state     = ST_HDR;
                end else if (!r_push_req) begin
                    w_push_req = 1'b1;
                end
            end

            ST_HDR: begin
                if (w_push_acc) begin
                    w_csum     = w_csum_sum;
                    w_push_req = 1'b0;
                    if (r_size == 8'd0) begin
                        w_push_data = w_csum_sum;
                        w_state     = ST_CSUM;
                    end else begin
                        w_pop_req = 1'b1;
                        w_state   = ST_POP;
                    end
                end else if (!r_push_req) begin
                    w_push_req = 1'b1;
                end
            end

            ST_POP: begin
                // Captured word is presented on the same edge the pop request falls.
                if (w_pop_acc) begin
                    w_pop_req   = 1'b0;
                    w_push_data = pop_data;
                    w_push_req  = 1'b1;
                    w_state     = ST_DATA;
                end
            end

            ST_DATA: begin
                if (w_push_acc) begin
                    w_csum     = w_csum_sum;
                    w_push_req = 1'b0;
                    w_remain   = r_remain - 8'd1;
                    if (r_remain == 8'd1) begin
                        w_push_data = w_csum_sum;
                        w_state     = ST_CSUM;
                    end else begin
                        w_pop_req = 1'b1;
                        w_state   = ST_POP;
                    end
                end else if (!r_push_req) begin
                    w_push_req = 1'b1;
                end
            end

            ST_CSUM: begin
                if (w_push_acc) begin
                    w_push_req  = 1'b0;
                    w_push_data = r_word_num;
                    w_state     = ST_WNUM;
                end else if (!r_push_req) begin
                    w_push_req = 1'b1;
                end
            end

            ST_WNUM: begin
                if (w_push_acc) begin
                    w_push_req  = 1'b0;
                    w_push_data = 16'h0000;
                    if (POSTFIX_WORDS == 0) begin
                        w_state = ST_FIN;
                    end else begin
                        w_state = ST_POST;
                    end
                end else if (!r_push_req) begin
                    w_push_req = 1'b1;
                end
            end

            ST_POST: begin
                if (w_push_acc) begin
                    w_push_req = 1'b0;
                    if (r_post_cnt == 4'd1) begin
                        w_state = ST_FIN;
                    end else begin
                        w_post_cnt = r_post_cnt - 4'd1;
                    end
                end else if (!r_push_req) begin
                    w_push_req = 1'b1;
                end
            end

            ST_FIN: begin
                // done and busy=0 land on the same edge; the counter wraps naturally.
                w_done     = 1'b1;
                w_busy     = 1'b0;
                w_word_num = r_word_num + 16'd1;
                w_state    = ST_IDLE;
            end

            default: begin
                w_state    = ST_IDLE;
                w_busy     = 1'b0;
                w_pop_req  = 1'b0;
                w_push_req = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame and clears the sequence number.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pop_req   <= 1'b0;
            r_push_req  <= 1'b0;
            r_push_data <= 16'h0000;
            r_word_num  <= 16'h0000;
            r_csum      <= 16'h0000;
            r_cmd       <= 8'h00;
            r_size      <= 8'h00;
            r_remain    <= 8'h00;
            r_post_cnt  <= 4'h0;
        end else begin
            r_state     <= w_state;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pop_req   <= w_pop_req;
            r_push_req  <= w_push_req;
            r_push_data <= w_push_data;
            r_word_num  <= w_word_num;
            r_csum      <= w_csum;
            r_cmd       <= w_cmd;
            r_size      <= w_size;
            r_remain    <= w_remain;
            r_post_cnt  <= w_post_cnt;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign pop_request  = r_pop_req;
    assign push_request = r_push_req;
    assign push_data    = r_push_data;
    assign word_num     = r_word_num;

endmodule

// File: tb/tb_service_reply_encoder.sv
// Purpose: directed self-checking bench for service_reply_encoder (POSTFIX_WORDS=2).
// Latency: samples outputs 1 time unit after each rising edge, drives inputs at the same point.
// Backpressure: acks are one-cycle pulses with 0..N random cycles of delay after each request rises.
module tb_service_reply_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic [7:0]  size;
    logic        busy;
    logic        done;
    logic        pop_request;
    logic [15:0] pop_data;
    logic        pop_done;
    logic        push_request;
    logic [15:0] push_data;
    logic        push_done;
    logic [15:0] word_num;

    int checks   = 0;
    int failures = 0;

    logic [15:0] pl [0:7];
    logic [15:0] got [$];
    logic [15:0] exp_q [$];
    int          npop;
    bit          stable_ok;
    int          cd;

    service_reply_encoder #(.POSTFIX_WORDS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .addr         (addr),
        .cmd          (cmd),
        .size         (size),
        .busy         (busy),
        .done         (done),
        .pop_request  (pop_request),
        .pop_data     (pop_data),
        .pop_done     (pop_done),
        .push_request (push_request),
        .push_data    (push_data),
        .push_done    (push_done),
        .word_num     (word_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents start for one edge and checks the address word appears on that edge.
    task automatic do_start(input logic [7:0] a, input logic [7:0] c, input logic [7:0] s);
        addr  = a;
        cmd   = c;
        size  = s;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_push_req", 32'(push_request), 32'd1);
        chk("start_addr_word", 32'(push_data), {16'h0, a, 8'h00});
        chk("start_done_low", 32'(done), 32'd0);
    endtask

    // Serves the push and pop handshakes until done; optionally injects a start at cycle inj_at.
    task automatic collect(input int pmax, input int qmax, input int inj_at, output int cyc_done);
        int          cyc;
        bit          preq;
        bit          qreq;
        int          pd;
        int          qd;
        logic [15:0] pdat;
        cyc = 0; preq = 0; qreq = 0; pd = 0; qd = 0; pdat = 16'h0;
        got.delete();
        npop      = 0;
        stable_ok = 1'b1;
        cyc_done  = -1;
        while (cyc < 3000) begin
            push_done = 1'b0;
            pop_done  = 1'b0;
            start     = 1'b0;
            if (done === 1'b1) begin
                cyc_done = cyc;
                break;
            end
            if (cyc == inj_at) begin
                start = 1'b1;
                addr  = 8'h55;
                cmd   = 8'h66;
                size  = 8'h03;
            end
            if (push_request === 1'b1) begin
                if (preq && (push_data !== pdat)) stable_ok = 1'b0;
                if (!preq) pd = int'($urandom_range(pmax));
                if (pd == 0) begin
                    push_done = 1'b1;
                    got.push_back(push_data);
                    preq = 1'b0;
                end else begin
                    pd--;
                    preq = 1'b1;
                    pdat = push_data;
                end
            end else begin
                preq = 1'b0;
            end
            if (pop_request === 1'b1) begin
                if (!qreq) qd = int'($urandom_range(qmax));
                if (qd == 0) begin
                    pop_done = 1'b1;
                    pop_data = (npop < 8) ? pl[npop] : 16'hDEAD;
                    npop++;
                    qreq = 1'b0;
                end else begin
                    qd--;
                    qreq = 1'b1;
                end
            end else begin
                qreq = 1'b0;
            end
            step();
            cyc++;
        end
        push_done = 1'b0;
        pop_done  = 1'b0;
        start     = 1'b0;
        chk("frame_done_seen", 32'(cyc_done >= 0), 32'd1);
    endtask

    // Expected frame: address, size/cmd, first s payload words, checksum, word number, two blanks.
    task automatic make_exp(input logic [7:0] a, input logic [7:0] c, input logic [7:0] s,
                            input logic [15:0] csum, input logic [15:0] wn);
        exp_q.delete();
        exp_q.push_back({a, 8'h00});
        exp_q.push_back({s, c});
        for (int i = 0; i < int'(s); i++) exp_q.push_back(pl[i]);
        exp_q.push_back(csum);
        exp_q.push_back(wn);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
    endtask

    task automatic cmp_frame(input string tag);
        logic [31:0] o;
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (i < got.size()) ? {16'h0, got[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_w%0d", tag, i), o, {16'h0, exp_q[i]});
        end
    endtask

    initial begin
        int  n;
        bit  reached;
        pl[0] = 16'hFFA1; pl[1] = 16'h0001; pl[2] = 16'hFFA3; pl[3] = 16'h0002;
        pl[4] = 16'hFFA3; pl[5] = 16'hAB45; pl[6] = 16'hFFA3; pl[7] = 16'hFFA1;
        rst = 1'b1; start = 1'b0; addr = 8'h00; cmd = 8'h00; size = 8'h00;
        pop_data = 16'h0; pop_done = 1'b0; push_done = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pop_req", 32'(pop_request), 32'd0);
        chk("rst_push_req", 32'(push_request), 32'd0);
        chk("rst_push_data", 32'(push_data), 32'd0);
        chk("rst_word_num", 32'(word_num), 32'd0);
        rst = 1'b0;
        step();

        // Size-0 frame: checksum AB00+00A0 = ABA0; 6 words -> 12 busy cycles
        do_start(8'hAB, 8'hA0, 8'h00);
        collect(0, 0, -1, cd);
        make_exp(8'hAB, 8'hA0, 8'h00, 16'hABA0, 16'h0000);
        cmp_frame("f1");
        chk("f1_cycles", 32'(cd), 32'd12);
        chk("f1_npop", 32'(npop), 32'd0);
        chk("f1_busy_at_done", 32'(busy), 32'd0);
        chk("f1_word_num", 32'(word_num), 32'd1);

        // Data frame started the cycle after done: checksum 5D15, 14 words -> 28 busy cycles
        do_start(8'hAB, 8'hA2, 8'h08);
        collect(0, 0, -1, cd);
        make_exp(8'hAB, 8'hA2, 8'h08, 16'h5D15, 16'h0001);
        cmp_frame("f2");
        chk("f2_cycles", 32'(cd), 32'd28);
        chk("f2_npop", 32'(npop), 32'd8);
        chk("f2_word_num", 32'(word_num), 32'd2);

        // Same data frame under random push/pop ack delays of 0..5 cycles
        step();
        do_start(8'hAB, 8'hA2, 8'h08);
        collect(5, 5, -1, cd);
        make_exp(8'hAB, 8'hA2, 8'h08, 16'h5D15, 16'h0002);
        cmp_frame("f3");
        chk("f3_stable", 32'(stable_ok), 32'd1);
        chk("f3_npop", 32'(npop), 32'd8);
        chk("f3_word_num", 32'(word_num), 32'd3);

        // Start pulse mid-frame (addr 55) must be dropped: checksum 1200+0034 = 1234
        step();
        do_start(8'h12, 8'h34, 8'h00);
        collect(0, 0, 4, cd);
        make_exp(8'h12, 8'h34, 8'h00, 16'h1234, 16'h0003);
        cmp_frame("f4");
        chk("f4_word_num", 32'(word_num), 32'd4);

        // Immediate restart after done: 5A00+0101+FFA1 = 5AA2 (mod 2^16)
        do_start(8'h5A, 8'h01, 8'h01);
        collect(0, 0, -1, cd);
        make_exp(8'h5A, 8'h01, 8'h01, 16'h5AA2, 16'h0004);
        cmp_frame("f5");
        chk("f5_npop", 32'(npop), 32'd1);
        chk("f5_word_num", 32'(word_num), 32'd5);

        // Idle after the frame: the dropped mid-frame start must not have queued
        repeat (3) step();
        chk("noqueue_busy", 32'(busy), 32'd0);
        chk("noqueue_push_req", 32'(push_request), 32'd0);

        // Stray acknowledges in IDLE
        push_done = 1'b1;
        pop_done  = 1'b1;
        repeat (3) step();
        push_done = 1'b0;
        pop_done  = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_done", 32'(done), 32'd0);
        chk("stray_push_req", 32'(push_request), 32'd0);
        chk("stray_pop_req", 32'(pop_request), 32'd0);
        chk("stray_word_num", 32'(word_num), 32'd5);

        // Reset while in DATA
        do_start(8'hAB, 8'hA2, 8'h08);
        reached = 1'b0;
        n = 0;
        while (n < 20 && !reached) begin
            if (pop_request === 1'b1) begin
                pop_done = 1'b1;
                pop_data = pl[0];
                push_done = 1'b0;
                reached = 1'b1;
            end else begin
                push_done = push_request;
            end
            step();
            pop_done  = 1'b0;
            push_done = 1'b0;
            n++;
        end
        chk("rdata_reached", 32'(reached), 32'd1);
        chk("rdata_push_req", 32'(push_request), 32'd1);
        chk("rdata_push_data", 32'(push_data), 32'hFFA1);
        rst = 1'b1;
        step();
        chk("rdata_rst_push_req", 32'(push_request), 32'd0);
        chk("rdata_rst_pop_req", 32'(pop_request), 32'd0);
        chk("rdata_rst_busy", 32'(busy), 32'd0);
        chk("rdata_rst_word_num", 32'(word_num), 32'd0);
        rst = 1'b0;
        step();

        // Full frame after reset with a fresh checksum and word number 0000
        do_start(8'hAB, 8'hA2, 8'h08);
        collect(0, 0, -1, cd);
        make_exp(8'hAB, 8'hA2, 8'h08, 16'h5D15, 16'h0000);
        cmp_frame("f7");
        chk("f7_npop", 32'(npop), 32'd8);
        chk("f7_word_num", 32'(word_num), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
